// File: rtl/i2s_pkg.sv
// Shared I2S types and constants for the Line In receive path.
package i2s_pkg;

  localparam int unsigned AUDIO_DATA_BITS = 24;

  typedef logic [AUDIO_DATA_BITS-1:0] audio_sample_t;

  typedef enum logic [0:0] {
    SEARCH,
    RUN
  } i2s_rx_state_t;

endpackage

// File: rtl/i2s_edge_sync.sv
// Brings BCLK, LRCK and SDATA into the CLK domain and flags BCLK rising edges.
// lrck_o/sdata_o come from the history flops so they line up with bclk_rise_o.
module i2s_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic bclk_i,
  input  logic lrck_i,
  input  logic sdata_i,
  output logic bclk_rise_o,
  output logic lrck_o,
  output logic sdata_o
);

  // Bit order in each stage: {bclk, lrck, sdata}
  logic [2:0] s1_q, s1_d, s2_q, s2_d, hist_q, hist_d;
  logic       rise_q, rise_d;

  // Synchronizer chain, history stage and registered rise detect
  always_comb begin
    s1_d   = {bclk_i, lrck_i, sdata_i};
    s2_d   = s1_q;
    hist_d = s2_q;
    rise_d = s2_q[2] & ~hist_q[2];
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= '0;
      s2_q   <= '0;
      hist_q <= '0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
    end
  end

  assign bclk_rise_o = rise_q;
  assign lrck_o      = hist_q[1];
  assign sdata_o     = hist_q[0];

endmodule

// File: rtl/i2s_slave_in.sv
// I2S slave receiver: slot framing, stereo pair handshake, sticky status and BCLK loss timeout.
module i2s_slave_in
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_BITS      = AUDIO_DATA_BITS,
  parameter int unsigned MAX_SLOT_BITS  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 BCLK_IN,
  input  logic                 LRCK_IN,
  input  logic                 SDATA_IN,
  output logic [DATA_BITS-1:0] LEFT_CHANNEL,
  output logic [DATA_BITS-1:0] RIGHT_CHANNEL,
  output logic                 DATA_VALID,
  input  logic                 ACK,
  output logic                 OVERRUN,
  output logic                 FRAME_ERROR,
  input  logic                 CLEAR_STATUS,
  output logic                 LOCKED
);

  localparam int unsigned CntW = $clog2(MAX_SLOT_BITS + 2);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] DataBitsC = CntW'(DATA_BITS);
  localparam logic [CntW-1:0] MaxSlotC  = CntW'(MAX_SLOT_BITS);
  localparam logic [CntW-1:0] SatC      = CntW'(MAX_SLOT_BITS + 1);
  localparam logic [TmoW-1:0] TmoMaxC   = TmoW'(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0] TmoLastC  = TmoW'(TIMEOUT_CYCLES - 1);

  logic bclk_rise, lrck_s, sdata_s;

  i2s_edge_sync u_edge_sync (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .bclk_i      (BCLK_IN),
    .lrck_i      (LRCK_IN),
    .sdata_i     (SDATA_IN),
    .bclk_rise_o (bclk_rise),
    .lrck_o      (lrck_s),
    .sdata_o     (sdata_s)
  );

  i2s_rx_state_t        state_q, state_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [TmoW-1:0]      tmo_q, tmo_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, left_hold_q, left_hold_d;
  logic [DATA_BITS-1:0] left_q, left_d, right_q, right_d;
  logic                 lrck_prev_q, lrck_prev_d, pending_q, pending_d;
  logic                 dv_q, dv_d, ovr_q, ovr_d, fe_q, fe_d, locked_q, locked_d;
  logic                 ws_change, publish, frame_err;
  logic [CntW-1:0]      cnt_inc;
  logic [DATA_BITS-1:0] word;

  // Slot framing, pair assembly, handshake, status and timeout next-state
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    lrck_prev_d = lrck_prev_q;
    pending_d   = pending_q;
    left_d      = left_q;
    right_d     = right_q;
    dv_d        = dv_q;
    ovr_d       = ovr_q;
    fe_d        = fe_q;
    locked_d    = locked_q;
    publish     = 1'b0;
    frame_err   = 1'b0;

    ws_change = (lrck_s != lrck_prev_q);
    // Bit count including the current bit; the ws_change bit is the closing slot's LSB
    cnt_inc   = (count_q == SatC) ? SatC : count_q + 1'b1;
    word      = (count_q < DataBitsC) ? {shift_q[DATA_BITS-2:0], sdata_s} : shift_q;
    tmo_d     = bclk_rise ? '0 : ((tmo_q == TmoMaxC) ? TmoMaxC : tmo_q + 1'b1);

    if (bclk_rise) begin
      lrck_prev_d = lrck_s;
      if (state_q == SEARCH) begin
        // The slot closing here is never evaluated: its start was not seen
        if (ws_change) begin
          state_d   = RUN;
          count_d   = '0;
          shift_d   = '0;
          pending_d = 1'b0;
        end
      end else if (ws_change) begin
        count_d = '0;
        shift_d = '0;
        if (cnt_inc < DataBitsC || cnt_inc > MaxSlotC) begin
          frame_err = 1'b1;
          pending_d = 1'b0;
        end else if (!lrck_prev_q) begin
          left_hold_d = word;
          pending_d   = 1'b1;
        end else if (pending_q) begin
          publish   = 1'b1;
          pending_d = 1'b0;
        end
      end else begin
        count_d = cnt_inc;
        if (count_q < DataBitsC) begin
          shift_d = {shift_q[DATA_BITS-2:0], sdata_s};
        end
      end
    end else if (tmo_q == TmoLastC) begin
      // BCLK lost: drop lock but keep the last published pair visible
      state_d   = SEARCH;
      count_d   = '0;
      pending_d = 1'b0;
      locked_d  = 1'b0;
    end

    if (publish) begin
      left_d   = left_hold_q;
      right_d  = word;
      dv_d     = 1'b1;
      locked_d = 1'b1;
    end else if (ACK) begin
      dv_d = 1'b0;
    end

    // Events are applied after the clear so they win a same-cycle collision
    if (CLEAR_STATUS) begin
      ovr_d = 1'b0;
      fe_d  = 1'b0;
    end
    if (publish && dv_q && !ACK) ovr_d = 1'b1;
    if (frame_err) fe_d = 1'b1;
  end

  // State registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= SEARCH;
      count_q     <= '0;
      tmo_q       <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      lrck_prev_q <= 1'b0;
      pending_q   <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      dv_q        <= 1'b0;
      ovr_q       <= 1'b0;
      fe_q        <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      tmo_q       <= tmo_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      lrck_prev_q <= lrck_prev_d;
      pending_q   <= pending_d;
      left_q      <= left_d;
      right_q     <= right_d;
      dv_q        <= dv_d;
      ovr_q       <= ovr_d;
      fe_q        <= fe_d;
      locked_q    <= locked_d;
    end
  end

  assign LEFT_CHANNEL  = left_q;
  assign RIGHT_CHANNEL = right_q;
  assign DATA_VALID    = dv_q;
  assign OVERRUN       = ovr_q;
  assign FRAME_ERROR   = fe_q;
  assign LOCKED        = locked_q;

endmodule

// File: doc/i2s_slave_in.md
Name: i2s_slave_in

Overview:
- I2S receiver for slave mode: BCLK and LRCK are driven by an external device (codec or ADC in master mode), not by our clock generator.
- Oversamples BCLK, LRCK and SDATA in the CLK domain and deserializes 24-bit stereo samples.
- Presents each left/right pair through a valid/ack handshake, with sticky overrun and frame-error status.
- Sits beside the audio IO block as the Line In path when the external codec owns the audio clocks.

Parameters:
- DATA_BITS, 24, bits captured per channel; MSB first, extra slot bits ignored.
- MAX_SLOT_BITS, 32, longest legal slot in BCLK periods; a longer slot is a frame error.
- TIMEOUT_CYCLES, 256, CLK cycles without a BCLK rising edge before the block drops lock.

Ports:
- CLK  in  1  system clock, 147.5MHz
- RESET  in  1  asynchronous reset, active high
- BCLK_IN  in  1  external bit clock, asynchronous to CLK
- LRCK_IN  in  1  external word select; 0 = left, 1 = right
- SDATA_IN  in  1  external serial data
- LEFT_CHANNEL  out  DATA_BITS  last completed left sample
- RIGHT_CHANNEL  out  DATA_BITS  last completed right sample
- DATA_VALID  out  1  new pair available; held until ACK
- ACK  in  1  consumer acknowledge; clears DATA_VALID
- OVERRUN  out  1  sticky: a pair was published while DATA_VALID=1
- FRAME_ERROR  out  1  sticky: short or over-long slot detected
- CLEAR_STATUS  in  1  clears OVERRUN and FRAME_ERROR
- LOCKED  out  1  in RUN state and at least one pair published since entering RUN

Behaviour:
- Reset values: all outputs 0, state SEARCH, shift register and counters 0.
- Input path: BCLK, LRCK and SDATA each pass through a 2-flop synchronizer plus a history flop. A BCLK rise is sync=1 with history=0.
- Sampling: on each BCLK rise, take the synchronized LRCK and SDATA.
  - ws_change = lrck_s != lrck_prev; update lrck_prev after the comparison.
- I2S one-bit delay: the bit sampled on the ws_change edge is the LSB of the slot that just ended. The next rise carries the new slot's MSB.
- Bit counter (per slot):
  - Counts bits including the ws_change bit.
  - Shifts SDATA into the shift register while count < DATA_BITS.
  - Saturates at MAX_SLOT_BITS+1.
- State SEARCH: discard bits; on ws_change go to RUN with count=0 and pending_left=0. The slot closed on this edge is not evaluated.
- State RUN, on ws_change (slot close, closing channel = lrck_prev):
  - If count < DATA_BITS or count > MAX_SLOT_BITS: set FRAME_ERROR, discard the word, clear pending_left.
  - Left closes OK: latch the word into left_hold and set pending_left.
  - Right closes OK with pending_left=1: publish. LEFT_CHANNEL=left_hold and RIGHT_CHANNEL=word, DATA_VALID=1, clear pending_left.
  - Right closes OK without pending_left: discard.
  - Always: reset count to 0.
- Latency: DATA_VALID rises on the 4th CLK edge after the closing BCLK rise is first sampled at the pin.
- Handshake:
  - ACK with DATA_VALID=1 clears it next cycle.
  - Publish and ACK in the same cycle: publish wins, DATA_VALID stays 1, no overrun.
  - Publish while DATA_VALID=1 without ACK: set OVERRUN; outputs are overwritten with the new pair.
- Status: CLEAR_STATUS clears both sticky flags. If an error event and CLEAR_STATUS occur in the same cycle, the event wins.
- Timeout: a counter is cleared on every BCLK rise. When it reaches TIMEOUT_CYCLES:
  - go to SEARCH; LOCKED=0; pending_left=0;
  - DATA_VALID and the data outputs are held unchanged.
- LOCKED: set on the first publish in RUN; cleared on entry to SEARCH.
- Input timing requirement: BCLK high and low phases of at least 3 CLK cycles each. Nominal system BCLK = CLK/64.
- Reset mid-frame: asynchronous clear to SEARCH. The partial frame is lost and the first pair appears only after a full left+right frame.

Decomposition:
- Shared package i2s_pkg holds:
  - AUDIO_DATA_BITS = 24
  - typedef audio_sample_t (logic [23:0])
  - typedef enum i2s_rx_state_t {SEARCH, RUN}
- One sub-module, i2s_edge_sync:
  - 2-flop synchronizer plus history flop for BCLK, LRCK and SDATA;
  - outputs bclk_rise, lrck_s, sdata_s.
- The slot, handshake and timeout logic stays in i2s_slave_in.

Test Plan:
- Normal frames: BCLK=CLK/64, 24-bit slots, left=0x123456, right=0xABCDEF, two frames → first frame absorbed by SEARCH; then DATA_VALID=1 with LEFT=0x123456, RIGHT=0xABCDEF; LOCKED=1; ACK clears DATA_VALID next cycle.
- 32-bit slots: left=0x800001 plus 8 trailing 1s, right=0x7FFFFF → LEFT=0x800001, RIGHT=0x7FFFFF; FRAME_ERROR=0.
- Short slot: left slot of 20 bits, then a valid 24-bit right slot → FRAME_ERROR=1, no publish for that frame; the next good frame publishes; CLEAR_STATUS drops FRAME_ERROR.
- Overrun: three good frames, ACK never asserted → OVERRUN=1 after the second publish; outputs hold frame 3; ACK coincident with a publish → DATA_VALID stays 1, OVERRUN unchanged.
- Timeout: stop BCLK for 300 CLK cycles → LOCKED=0 by cycle 256+3; restart → LOCKED=1 only after one discarded slot plus one full frame.
- Async reset asserted mid right slot → all outputs 0 immediately, without waiting for a clock edge; after release, the first publish occurs only after a full subsequent frame.
